shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencer for the gate-level shift-register chains: accepts a parallel word on a single-cycle start request, serializes it LSB-first onto the chain's serial data input with a per-bit shift enable, and captures the chain's tail bit each shift into a parallel result word. It sits between a host and any `dff`-based shift chain, and owns all sequencing of that chain: load, bit count, completion and abort.

## Interface
- `WIDTH`, default 8: bits per transfer; legal range 2..32.
- `C`, input, 1: clock; all state updates on the rising edge.
- `R`, input, 1: reset, asynchronous and active-high.
- `START`, input, 1: transfer request, sampled only in IDLE.
- `DIN`, input, WIDTH: parallel word to shift out, latched on accepted `START`.
- `SI`, input, 1: serial input from the tail of the shift chain.
- `SD`, output, 1: serial data to the head of the chain.
- `SE`, output, 1: shift enable to the chain; high exactly one cycle per bit.
- `BUSY`, output, 1: high from the cycle after acceptance through the DONE cycle.
- `DONE`, output, 1: single-cycle completion pulse.
- `DOUT`, output, WIDTH: captured word; valid from DONE until the next acceptance.
- `PAR`, output, 1: even parity of `DOUT` (see Configuration).

## Operation
- FSM states are IDLE, SHIFT and FIN.
- IDLE: `BUSY`=0, `SE`=0. If `START`=1, latch `DIN` into a shadow register, clear the bit counter and go to SHIFT.
- SHIFT: `SE`=1 and `SD`=shadow[0]. On each edge:
  - shadow shifts right;
  - capture register shifts right with `SI` entering the MSB;
  - counter increments.
- SHIFT → FIN on the edge where the counter reaches WIDTH-1, so there are exactly WIDTH SHIFT cycles.
- FIN: `DONE`=1, `SE`=0, then unconditionally → IDLE.
- The first `SI` sample lands in `DOUT[0]`. With `SI` looped to `SD`, `DOUT` equals `DIN`.
- `DOUT` is updated only by the capture register. It holds its value in IDLE.
- `START` in SHIFT or FIN is ignored: not queued, no error. `DIN` changes after acceptance have no effect.
- The counter is $clog2(WIDTH) bits wide, unsigned, and wraps to 0 on entering FIN.

## Timing
- All outputs are registered, with no combinational path from `START` or `SI` to any output.
- Reset values: state=IDLE, `SD`=0, `SE`=0, `BUSY`=0, `DONE`=0, `DOUT`=0, `PAR`=0; shadow and counter are 0.
- `START` high at edge k: `BUSY` and `SE` rise after edge k, and SHIFT occupies cycles k+1..k+WIDTH.
- `DONE` is high in cycle k+WIDTH+1 and `BUSY` falls after edge k+WIDTH+1.
- Earliest next acceptance is edge k+WIDTH+2, giving a throughput of WIDTH+2 cycles per word.
- `SI` is sampled on the same edge the chain shifts, so the controller sees the chain's tail value before that shift.
- `R` asserted mid-transfer aborts immediately: no `DONE` and no partial `DOUT` update. Operation resumes in IDLE on the first edge after `R` is released.
- `START` held high continuously gives back-to-back transfers, each separated by the FIN cycle plus one IDLE cycle.

## Configuration
- `SHIFT_SEQ_PARITY_EN` defined:
  - a parity bit accumulates the XOR of `SI` samples during SHIFT and clears on acceptance;
  - `PAR` registers that value at FIN and holds it until the next FIN or reset.
- Not defined: `PAR` is tied to 0 and no parity logic is built.

## Structure
- Package `shift_seq_pkg` holds:
  - the state typedef, 2-bit encoding: IDLE=0, SHIFT=1, FIN=2; value 3 is illegal and recovers to IDLE;
  - the constants `SHIFT_SEQ_WMIN`=2 and `SHIFT_SEQ_WMAX`=32.
- One sub-module, `shift_seq_bitcnt`, holds the bit counter:
  - inputs: clear, increment;
  - output: terminal flag (count == WIDTH-1).
- FSM, shadow and capture registers stay in `shift_seq_ctrl`.

## Test plan
- Reset: `R` pulse mid-simulation with no `START` → all outputs 0; the state stays IDLE for 20 cycles.
- Loopback, WIDTH=8, `SI`=`SD`, `DIN`=8'hA5 → `SD` sequence 1,0,1,0,0,1,0,1; `DONE` exactly 9 cycles after acceptance; `DOUT`=8'hA5; `PAR`=0 with the macro defined.
- Two-stage chain (`shift_REG_2bits`) between `SD` and `SI`, chain pre-cleared, `DIN`=8'h07 → `DOUT`=8'h1C; `PAR`=1 with the macro defined, 0 without.
- `START` pulsed during SHIFT and during FIN → ignored, exactly one `DONE`; `START` held high → `DONE` pulses every 10 cycles.
- `R` asserted at the 4th SHIFT cycle → `SE`, `BUSY` and `DONE` go to 0 immediately, with no `DONE` pulse; a fresh transfer after release completes correctly.
- WIDTH=2 edge case: `DIN`=2'b10 in loopback → exactly 2 `SE` cycles, `DOUT`=2'b10.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and limits for the shift-chain sequencer.
package shift_seq_pkg;

   localparam int unsigned SHIFT_SEQ_WMIN = 2;
   localparam int unsigned SHIFT_SEQ_WMAX = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StFin   = 2'd2
   } shift_seq_state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Host/chain signal bundle for shift_seq_ctrl; master = host side, slave = sequencer.
interface shift_seq_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             START;
   logic [WIDTH-1:0] DIN;
   logic             SI;
   logic             SD;
   logic             SE;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] DOUT;
   logic             PAR;

   modport master (
      output START, DIN, SI,
      input  SD, SE, BUSY, DONE, DOUT, PAR
   );

   modport slave (
      input  START, DIN, SI,
      output SD, SE, BUSY, DONE, DOUT, PAR
   );
endinterface

// File: rtl/shift_seq_bitcnt.sv
// Bit counter for shift_seq_ctrl; flags the last bit and wraps to 0 when stepped past it.
module shift_seq_bitcnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic term_o
);
   localparam int unsigned CntW = $clog2(WIDTH);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign term_o = (cnt_q == CntW'(WIDTH - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         // Explicit wrap keeps non-power-of-two widths correct
         cnt_d = term_o ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/shift_seq_ctrl.sv
// LSB-first serializer/capturer for a dff shift chain.
// Optional parity on the captured word when SHIFT_SEQ_PARITY_EN is defined.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic              C,
   input logic              R,
   shift_seq_ctrl_if.slave  bus
);
   shift_seq_state_e state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             cnt_clr, cnt_inc, cnt_term;

   shift_seq_bitcnt #(
      .WIDTH (WIDTH)
   ) u_bitcnt (
      .clk_i  (C),
      .rst_i  (R),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .term_o (cnt_term)
   );

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cap_d    = cap_q;
      dout_d   = dout_q;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.START) begin
               shadow_d = bus.DIN;
               cnt_clr  = 1'b1;
               state_d  = StShift;
            end
         end
         StShift: begin
            shadow_d = shadow_q >> 1;
            cap_d    = {bus.SI, cap_q[WIDTH-1:1]};
            cnt_inc  = 1'b1;
            if (cnt_term) begin
               // Publish only complete words so an abort never exposes a partial capture
               dout_d  = cap_d;
               state_d = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state_q  <= StIdle;
         shadow_q <= '0;
         cap_q    <= '0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cap_q    <= cap_d;
         dout_q   <= dout_d;
      end
   end

   assign bus.SE   = (state_q == StShift);
   assign bus.SD   = (state_q == StShift) & shadow_q[0];
   assign bus.BUSY = (state_q == StShift) | (state_q == StFin);
   assign bus.DONE = (state_q == StFin);
   assign bus.DOUT = dout_q;

`ifdef SHIFT_SEQ_PARITY_EN
   logic acc_q, acc_d, par_q, par_d;

   always_comb begin
      acc_d = acc_q;
      par_d = par_q;
      if (state_q == StIdle && bus.START) begin
         acc_d = 1'b0;
      end else if (state_q == StShift) begin
         acc_d = acc_q ^ bus.SI;
         if (cnt_term) begin
            par_d = acc_d;
         end
      end
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         acc_q <= 1'b0;
         par_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         par_q <= par_d;
      end
   end

   assign bus.PAR = par_q;
`else
   assign bus.PAR = 1'b0;
`endif
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: WIDTH=8 with loopback/2-stage chain/random SI,
// plus a WIDTH=2 instance in loopback. Expected PAR follows SHIFT_SEQ_PARITY_EN.
module tb_shift_seq_ctrl;
`ifdef SHIFT_SEQ_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   logic C = 1'b0;
   logic R = 1'b1;
   always #5 C = ~C;

   shift_seq_ctrl_if #(.WIDTH(8)) bus8 ();
   shift_seq_ctrl_if #(.WIDTH(2)) bus2 ();

   shift_seq_ctrl #(.WIDTH(8)) dut8 (.C(C), .R(R), .bus(bus8));
   shift_seq_ctrl #(.WIDTH(2)) dut2 (.C(C), .R(R), .bus(bus2));

   int   n_chk  = 0;
   int   n_fail = 0;
   int   si_mode = 0;
   logic si_rand = 1'b0;
   logic chain_clr = 1'b0;
   logic [1:0] chain_q = 2'b00;

   // Two-stage dff chain between SD and SI, shifting with SE
   always @(posedge C) begin
      if (chain_clr) chain_q <= 2'b00;
      else if (bus8.SE) chain_q <= {chain_q[0], bus8.SD};
   end

   assign bus8.SI = (si_mode == 0) ? bus8.SD : (si_mode == 1) ? chain_q[1] : si_rand;
   assign bus2.SI = bus2.SD;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Chain of depth d preloaded with zeros returns DIN delayed by d bits
   task automatic xfer(input logic [7:0] din, input int mode);
      logic [7:0] exp_w;
      logic       b;
      si_mode = mode;
      if (mode == 1) begin
         chain_clr = 1'b1; tick(); chain_clr = 1'b0;
      end
      exp_w = 8'h00;
      if (mode == 0) exp_w = din;
      if (mode == 1) exp_w = din << 2;
      bus8.DIN = din; bus8.START = 1'b1;
      tick();
      bus8.START = 1'b0; bus8.DIN = 8'($urandom);
      check("busy_after_accept", bus8.BUSY, 1);
      for (int i = 0; i < 8; i++) begin
         if (mode == 2) begin
            b = 1'($urandom); si_rand = b; exp_w[i] = b;
         end
         check($sformatf("se_bit%0d", i), bus8.SE, 1);
         check($sformatf("sd_bit%0d", i), bus8.SD, din[i]);
         check($sformatf("done_low_bit%0d", i), bus8.DONE, 0);
         tick();
      end
      check("done_pulse", bus8.DONE, 1);
      check("se_fin", bus8.SE, 0);
      check("dout", bus8.DOUT, exp_w);
      check("par", bus8.PAR, ParEn ? ^exp_w : 1'b0);
      tick();
      check("done_cleared", bus8.DONE, 0);
      check("busy_cleared", bus8.BUSY, 0);
      check("dout_hold", bus8.DOUT, exp_w);
   endtask

   initial begin
      int         dones;
      int         done_at[$];
      logic [7:0] d;

      bus8.START = 1'b0; bus8.DIN = '0;
      bus2.START = 1'b0; bus2.DIN = '0;

      // Power-on reset
      tick();
      check("rst_sd", bus8.SD, 0);
      check("rst_se", bus8.SE, 0);
      check("rst_busy", bus8.BUSY, 0);
      check("rst_done", bus8.DONE, 0);
      check("rst_dout", bus8.DOUT, 0);
      check("rst_par", bus8.PAR, 0);
      R = 1'b0;
      tick();

      xfer(8'hA5, 0);
      xfer(8'h07, 1);

      // Mid-sim reset with no START: DOUT clears, sequencer stays idle
      R = 1'b1; #1;
      check("rst2_dout", bus8.DOUT, 0);
      check("rst2_par", bus8.PAR, 0);
      tick();
      R = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("idle_hold", {bus8.SE, bus8.BUSY, bus8.DONE, bus8.SD}, 0);
      end

      // START pulses during SHIFT (edge 4) and FIN (edge 9) are ignored
      si_mode = 0; dones = 0; done_at.delete();
      for (int c = 0; c < 30; c++) begin
         bus8.START = (c == 0) || (c == 4) || (c == 9);
         bus8.DIN = 8'($urandom);
         tick();
         if (bus8.DONE) begin dones++; done_at.push_back(c); end
      end
      bus8.START = 1'b0;
      check("ignore_done_count", dones, 1);
      if (done_at.size() > 0) check("ignore_done_edge", done_at[0], 8);

      // START held high: one word every WIDTH+2 cycles
      dones = 0; done_at.delete();
      bus8.START = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus8.DIN = 8'($urandom);
         tick();
         if (bus8.DONE) begin dones++; done_at.push_back(c); end
      end
      bus8.START = 1'b0;
      check("held_done_count", dones, 4);
      for (int i = 1; i < done_at.size(); i++)
         check("held_done_period", done_at[i] - done_at[i-1], 10);
      tick(); tick();

      // Abort at the 4th SHIFT cycle
      bus8.DIN = 8'h3C; bus8.START = 1'b1;
      tick();
      bus8.START = 1'b0;
      tick(); tick(); tick();
      check("abort_pre_se", bus8.SE, 1);
      R = 1'b1; #1;
      check("abort_se", bus8.SE, 0);
      check("abort_busy", bus8.BUSY, 0);
      check("abort_done", bus8.DONE, 0);
      check("abort_dout", bus8.DOUT, 0);
      tick();
      R = 1'b0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus8.DONE) dones++;
      end
      check("abort_no_done", dones, 0);
      xfer(8'h96, 0);

      // Random words across all SI sources
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         xfer(d, int'($urandom_range(0, 2)));
      end

      // WIDTH=2 loopback
      bus2.DIN = 2'b10; bus2.START = 1'b1;
      tick();
      bus2.START = 1'b0; bus2.DIN = 2'b01;
      check("w2_se0", bus2.SE, 1);
      check("w2_sd0", bus2.SD, 0);
      tick();
      check("w2_se1", bus2.SE, 1);
      check("w2_sd1", bus2.SD, 1);
      tick();
      check("w2_se_fin", bus2.SE, 0);
      check("w2_done", bus2.DONE, 1);
      check("w2_dout", bus2.DOUT, 2'b10);
      check("w2_par", bus2.PAR, ParEn ? 1'b1 : 1'b0);
      tick();
      check("w2_idle", {bus2.SE, bus2.BUSY, bus2.DONE}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
